// File: rtl/fwd_pkg.sv
// ---------------------------------------------------------------------------
// fwd_pkg
// Shared types and constants for the forwarding / hazard detection unit.
//   fwd_sel_width() : width of a per-port forward select (clog2(DEPTH+1))
//   FWD_RF          : select value meaning "take operand from register file"
//   fwd_rn_t        : register number as stored in the tracking pipe
//   fwd_entry_t     : one tracking-pipe entry {v, rn, ld}
// Register numbers are held at RN_MAX bits inside the pipe; narrower RW
// values are zero-extended on entry and on compare, so RW <= RN_MAX.
// ---------------------------------------------------------------------------
package fwd_pkg;

   localparam int RN_MAX = 16;

   // Forward select encoding: 0 = register file, k = tracked stage k.
   localparam int FWD_RF = 0;

   typedef logic [RN_MAX-1:0] fwd_rn_t;

   typedef struct packed {
      logic    v;    // entry holds a live register writer
      fwd_rn_t rn;   // destination register number
      logic    ld;   // writer is a load
   } fwd_entry_t;

   function automatic int fwd_sel_width(input int depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fwd_match.sv
// ---------------------------------------------------------------------------
// fwd_match
// Single-port priority matcher. Finds the nearest tracked stage whose
// destination equals this port's source register.
// Ports:
//   rs     in   source register number (zero-extended)
//   ruse   in   port actually reads rs
//   pipe   in   tracking pipe, entry 0 = EXE
//   sel    out  0 = register file, k+1 = forward from entry k
//   ld_hit out  matched entry is a load whose data is not yet forwardable
// ---------------------------------------------------------------------------
module fwd_match
   import fwd_pkg::*;
#(
   parameter int DEPTH    = 3,
   parameter int SW       = 2,
   parameter int LD_AVAIL = 1
) (
   input  fwd_rn_t                rs,
   input  logic                   ruse,
   input  fwd_entry_t [DEPTH-1:0] pipe,
   output logic [SW-1:0]          sel,
   output logic                   ld_hit
);

   // Scan from the oldest stage toward EXE so that the last hit written,
   // i.e. the lowest index, wins. r0 is hard-wired zero and never matches.
   always_comb begin
      sel    = SW'(FWD_RF);
      ld_hit = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (ruse && (rs != '0) && pipe[k].v && (pipe[k].rn == rs)) begin
            sel    = SW'(k + 1);
            ld_hit = pipe[k].ld && (k < LD_AVAIL);
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
// Tracks the destination registers of the instructions in the DEPTH stages
// downstream of decode, produces per-port forward selects for the decode
// instruction and a load-use stall.
// Ports:
//   clk        in   clock, rising edge
//   clrn       in   asynchronous active-low reset
//   id_valid   in   decode instruction valid
//   id_rs      in   packed source registers, port p at [p*RW +: RW]
//   id_ruse    in   per-port source-used flag
//   id_wreg    in   decode instruction writes a register
//   id_rd      in   decode destination register
//   id_m2reg   in   decode instruction is a load
//   flush      in   kill the decode instruction this cycle
//   stall      out  hold PC and IF/ID, insert bubble
//   fwd        out  per-port forward select, port p at [p*SW +: SW]
//   stall_cnt  out  saturating count of stall cycles
// ---------------------------------------------------------------------------
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int  RW       = 5,
   parameter int  NPORT    = 2,
   parameter int  DEPTH    = 3,
   parameter int  LD_AVAIL = 1,
   localparam int SW       = fwd_sel_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  clrn,
   input  logic                  id_valid,
   input  logic [NPORT*RW-1:0]   id_rs,
   input  logic [NPORT-1:0]      id_ruse,
   input  logic                  id_wreg,
   input  logic [RW-1:0]         id_rd,
   input  logic                  id_m2reg,
   input  logic                  flush,
   output logic                  stall,
   output logic [NPORT*SW-1:0]   fwd,
   output logic [15:0]           stall_cnt
);

   fwd_entry_t [DEPTH-1:0] pipe_reg;
   fwd_entry_t [DEPTH-1:0] pipe_next;
   logic [15:0]            stall_cnt_reg;
   logic [15:0]            stall_cnt_next;

   logic [NPORT-1:0]       ld_hit;
   logic [NPORT*SW-1:0]    sel_raw;
   logic                   hazard;

   // ---------------- per-port matchers ----------------
   generate
      for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
         fwd_match #(
            .DEPTH    (DEPTH),
            .SW       (SW),
            .LD_AVAIL (LD_AVAIL)
         ) u_match (
            .rs     (fwd_rn_t'(id_rs[gi*RW +: RW])),
            .ruse   (id_ruse[gi]),
            .pipe   (pipe_reg),
            .sel    (sel_raw[gi*SW +: SW]),
            .ld_hit (ld_hit[gi])
         );
      end
   endgenerate

   assign hazard = |ld_hit;

   // A flushed or invalid decode slot never needs to wait for load data.
   assign stall  = hazard && id_valid && !flush;

   // Selects are meaningless while the instruction is held back.
   assign fwd    = stall ? '0 : sel_raw;

   // ---------------- tracking pipe next state ----------------
   // Older entries advance every cycle even during a stall: the stages
   // downstream keep moving and a bubble is what enters EXE.
   always_comb begin
      pipe_next = pipe_reg;
      pipe_next[0] = '0;
      if (id_valid && id_wreg && (id_rd != '0) && !stall && !flush) begin
         pipe_next[0].v  = 1'b1;
         pipe_next[0].rn = fwd_rn_t'(id_rd);
         pipe_next[0].ld = id_m2reg;
      end
      for (int k = 1; k < DEPTH; k++) begin
         pipe_next[k] = pipe_reg[k-1];
      end
   end

   // ---------------- stall counter next state ----------------
   always_comb begin
      stall_cnt_next = stall_cnt_reg;
      if (stall && (stall_cnt_reg != 16'hFFFF)) begin
         stall_cnt_next = stall_cnt_reg + 16'd1;
      end
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         pipe_reg      <= '0;
         stall_cnt_reg <= 16'd0;
      end else begin
         pipe_reg      <= pipe_next;
         stall_cnt_reg <= stall_cnt_next;
      end
   end

   assign stall_cnt = stall_cnt_reg;

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter RW, default 5, register-number width.
REQ-002 SHALL have parameter NPORT, default 2, number of source-operand read ports.
REQ-003 SHALL have parameter DEPTH, default 3, number of tracked downstream stages (1=EXE, 2=MEM, 3=WB).
REQ-004 SHALL have parameter LD_AVAIL, default 1, first tracked-stage index (0-based) from which load data is forwardable.
REQ-005 SHALL define SW = clog2(DEPTH+1) as the forward-select width.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port clrn  input  1  asynchronous active-low reset.
REQ-008 SHALL have port id_valid  input  1  decode-stage instruction valid.
REQ-009 SHALL have port id_rs  input  NPORT*RW  packed source register numbers, port p at [p*RW +: RW].
REQ-010 SHALL have port id_ruse  input  NPORT  per-port source-used flag.
REQ-011 SHALL have port id_wreg  input  1  decode instruction writes a register.
REQ-012 SHALL have port id_rd  input  RW  decode destination register number.
REQ-013 SHALL have port id_m2reg  input  1  decode instruction is a load.
REQ-014 SHALL have port flush  input  1  kill the decode-stage instruction this cycle.
REQ-015 SHALL have port stall  output  1  hold PC and IF/ID, insert bubble.
REQ-016 SHALL have port fwd  output  NPORT*SW  per-port select: 0=register file, k=tracked stage k.
REQ-017 SHALL have port stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-018 SHALL hold a tracking pipe of DEPTH entries {v, rn, ld}; entry 0 = EXE.
REQ-019 On each rising clk, entry[k] SHALL load entry[k-1] for k>=1, regardless of stall.
REQ-020 Entry 0 SHALL load {1, id_rd, id_m2reg} when id_valid & id_wreg & id_rd!=0 & !stall & !flush, else a bubble (v=0).
REQ-021 For port p with id_ruse[p]=1 and rs!=0, the match SHALL be the lowest k with entry[k].v & entry[k].rn==rs (nearest stage wins).
REQ-022 fwd[p] SHALL be k+1 for a match, 0 for no match, unused port, or rs==0.
REQ-023 Load-use hazard SHALL exist when any port's match has ld=1 and k<LD_AVAIL.
REQ-024 stall SHALL equal hazard & id_valid & !flush, combinationally.
REQ-025 While stall=1, all fwd fields SHALL be 0.
REQ-026 A flush and a hazard in the same cycle SHALL give stall=0 and a bubble into entry 0.
REQ-027 stall_cnt SHALL increment by 1 on each clk with stall=1 and saturate at 16'hFFFF.
REQ-028 Register number 0 SHALL never be entered, matched, or forwarded.

Reset
REQ-029 clrn=0 SHALL asynchronously clear every entry's v, rn and ld, and set stall_cnt to 0.
REQ-030 With the pipe empty after reset, stall and all fwd fields SHALL be 0.
REQ-031 Reset asserted mid-stall SHALL drop stall in the same cycle, with no entry surviving.

Structure
REQ-032 Package fwd_pkg SHALL hold the SW clog2 function, the fwd encoding constants (FWD_RF=0), and the entry struct typedef.
REQ-033 A sub-module fwd_match SHALL implement the single-port priority matcher (outputs fwd and load-hit), instantiated NPORT times.
REQ-034 The tracking pipe and stall_cnt SHALL be the only sequential state.

Verification (defaults RW=5, NPORT=2, DEPTH=3, LD_AVAIL=1)
REQ-035 Sequence: add r3,r1,r2 issued, then sub r4,r3,r1 on the next cycle -> fwd port0=1, port1=0, stall=0.
REQ-036 Sequence: add r3 issued, then one bubble, then a consumer of r3 -> fwd=2; with two bubbles -> fwd=3; with three bubbles -> fwd=0.
REQ-037 Sequence: lw r5, then add r6,r5,r5 -> stall=1 for exactly one cycle with fwd=0 and stall_cnt 0->1, then fwd port0=port1=2.
REQ-038 Writers to r3 in both EXE and MEM, consumer reads r3 -> fwd=1; writer to r0, consumer reads r0 -> fwd=0.
REQ-039 Load-use hazard with flush=1 in the same cycle -> stall=0 and entry 0 bubble; clrn pulsed low during a stall -> stall=0, stall_cnt=0 immediately.
REQ-040 Forcing 65540 consecutive load-use stalls -> stall_cnt holds at 16'hFFFF.
